rx_perf_monitor: RTL and testbench

//  Receiver-side 4-ASK decision and performance-measurement block for one rail (I or Q).

---
 rtl/rx_perf_monitor_if.sv | 27 ++
 rtl/rx_perf_monitor.sv | 142 ++++++++++++++
 tb/tb_rx_perf_monitor.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_perf_monitor_if.sv
// Symbol-rate inputs and registered measurement results of one rx_perf_monitor rail.
// The master side feeds samples and cycle pulses; the slave side is the monitor itself.
interface rx_perf_monitor_if #(
    parameter int LFSR_LEN = 8
);
    logic                        sam_clk_en;
    logic                        sym_clk_en;
    logic                        cycle_periodic;
    logic                        cycle_periodic_behind;
    logic signed [17:0]          rx_channel_sync;
    logic        [1:0]           rx_data;
    logic signed [17:0]          ref_level;
    logic signed [17:0]          avg_power;
    logic signed [17:0]          acc_sq_err_dec;
    logic signed [35+LFSR_LEN:0] acc_sq_err_full;
    logic signed [17:0]          acc_dc_err;

    modport master (
        output sam_clk_en, sym_clk_en, cycle_periodic, cycle_periodic_behind, rx_channel_sync,
        input  rx_data, ref_level, avg_power, acc_sq_err_dec, acc_sq_err_full, acc_dc_err
    );

    modport slave (
        input  sam_clk_en, sym_clk_en, cycle_periodic, cycle_periodic_behind, rx_channel_sync,
        output rx_data, ref_level, avg_power, acc_sq_err_dec, acc_sq_err_full, acc_dc_err
    );
endinterface

// File: rtl/rx_perf_monitor.sv
// 4-ASK slicer plus per-LFSR-cycle power, MSE and DC-error measurement for one rail.
// Define RX_PERF_DC_EN to build the DC-error accumulator; otherwise acc_dc_err is tied to 0.
module rx_perf_monitor #(
    parameter int LFSR_LEN = 8
) (
    input  logic             sys_clk,
    input  logic             reset,
    rx_perf_monitor_if.slave bus
);
    localparam int ACC_W = 18 + LFSR_LEN;
    localparam int SQ_W  = 36 + LFSR_LEN;

    logic signed [17:0]      w_x;
    logic signed [17:0]      w_absX;
    logic signed [17:0]      w_err;
    logic signed [18:0]      w_x19;
    logic signed [18:0]      w_ref19;
    logic signed [18:0]      w_half;
    logic signed [18:0]      w_three;
    logic signed [18:0]      w_level;
    logic signed [19:0]      w_err20;
    logic signed [35:0]      w_sqX;
    logic signed [35:0]      w_sqErr;
    logic        [1:0]       w_slice;
    logic                    w_unusedSamClkEn;

    logic signed [17:0]      r_s;
    logic        [1:0]       r_rxData;
    logic signed [17:0]      r_refLevel;
    logic signed [17:0]      r_avgPower;
    logic signed [17:0]      r_sqErrDec;
    logic signed [ACC_W-1:0] r_absAcc;
    logic signed [SQ_W-1:0]  r_pwrAcc;
    logic signed [SQ_W-1:0]  r_sqAcc;
    logic signed [SQ_W-1:0]  r_sqErrFull;

    assign w_unusedSamClkEn = bus.sam_clk_en;
    assign w_x     = bus.rx_channel_sync;
    assign w_x19   = 19'(w_x);
    assign w_ref19 = 19'(r_refLevel);
    assign w_half  = w_ref19 >>> 1;
    assign w_three = w_ref19 + w_half;
    assign w_absX  = (w_x == 18'sh20000) ? 18'sh1FFFF : (w_x[17] ? -w_x : w_x);
    assign w_sqX   = 36'(w_x) * 36'(w_x);

    // The mean |x| doubles as the decision threshold between inner and outer levels.
    always_comb begin
        w_slice = 2'b00;
        if (w_x19 >= w_ref19)
            w_slice = 2'b10;
        else if (!w_x[17])
            w_slice = 2'b11;
        else if (w_x19 > -w_ref19)
            w_slice = 2'b01;
        else
            w_slice = 2'b00;
    end

    always_comb begin
        w_level = -w_three;
        case (r_rxData)
            2'b11:   w_level = w_half;
            2'b01:   w_level = -w_half;
            2'b10:   w_level = w_three;
            default: w_level = -w_three;
        endcase
    end

    // Error saturates symmetrically so that e*e always stays below 2^34.
    assign w_err20 = 20'(r_s) - 20'(w_level);
    always_comb begin
        w_err = w_err20[17:0];
        if (w_err20 > 20'sd131071)
            w_err = 18'sd131071;
        else if (w_err20 < -20'sd131071)
            w_err = -18'sd131071;
    end
    assign w_sqErr = 36'(w_err) * 36'(w_err);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_s         <= '0;
            r_rxData    <= '0;
            r_refLevel  <= '0;
            r_avgPower  <= '0;
            r_sqErrDec  <= '0;
            r_sqErrFull <= '0;
            r_absAcc    <= '0;
            r_pwrAcc    <= '0;
            r_sqAcc     <= '0;
        end else if (bus.sym_clk_en) begin
            r_s      <= w_x;
            r_rxData <= w_slice;
            if (bus.cycle_periodic) begin
                r_refLevel <= 18'(r_absAcc >>> LFSR_LEN);
                r_avgPower <= 18'(r_pwrAcc >>> (LFSR_LEN + 17));
                r_absAcc   <= ACC_W'(w_absX);
                r_pwrAcc   <= SQ_W'(w_sqX);
            end else begin
                r_absAcc   <= r_absAcc + ACC_W'(w_absX);
                r_pwrAcc   <= r_pwrAcc + SQ_W'(w_sqX);
            end
            // Error path runs one symbol behind, so it dumps on the delayed pulse.
            if (bus.cycle_periodic_behind) begin
                r_sqErrFull <= r_sqAcc;
                r_sqErrDec  <= r_sqAcc[LFSR_LEN+34:LFSR_LEN+17];
                r_sqAcc     <= SQ_W'(w_sqErr);
            end else begin
                r_sqAcc     <= r_sqAcc + SQ_W'(w_sqErr);
            end
        end
    end

`ifdef RX_PERF_DC_EN
    logic signed [ACC_W-1:0] r_dcAcc;
    logic signed [17:0]      r_dcErr;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_dcAcc <= '0;
            r_dcErr <= '0;
        end else if (bus.sym_clk_en) begin
            if (bus.cycle_periodic_behind) begin
                r_dcErr <= 18'(r_dcAcc >>> LFSR_LEN);
                r_dcAcc <= ACC_W'(w_err);
            end else begin
                r_dcAcc <= r_dcAcc + ACC_W'(w_err);
            end
        end
    end

    assign bus.acc_dc_err = r_dcErr;
`else
    assign bus.acc_dc_err = '0;
`endif

    assign bus.rx_data         = r_rxData;
    assign bus.ref_level       = r_refLevel;
    assign bus.avg_power       = r_avgPower;
    assign bus.acc_sq_err_dec  = r_sqErrDec;
    assign bus.acc_sq_err_full = r_sqErrFull;
endmodule

// File: tb/tb_rx_perf_monitor.sv
// Scoreboard bench for rx_perf_monitor: a list-based reference model predicts every clock,
// a monitor process compares, and directed checks pin the known steady-state values.
module tb_rx_perf_monitor;
    localparam int LFSR_LEN = 8;
    localparam int N = 1 << LFSR_LEN;
`ifdef RX_PERF_DC_EN
    localparam longint DC_STEADY = -32768;
    localparam bit     DC_BUILT  = 1'b1;
`else
    localparam longint DC_STEADY = 0;
    localparam bit     DC_BUILT  = 1'b0;
`endif

    typedef struct {
        logic [1:0] rxData;
        longint     refLevel;
        longint     avgPower;
        longint     sqDec;
        longint     sqFull;
        longint     dcErr;
    } expT;

    logic   sys_clk = 1'b0;
    logic   reset;
    int     compared = 0;
    int     mismatched = 0;
    expT    expQ[$];

    // Reference model: decisions and per-cycle lists of errors, summed at each dump.
    longint     mR = 0, mAvg = 0, mSqFull = 0, mSqDec = 0, mDc = 0, mS = 0;
    longint     absSum = 0, pwrSum = 0;
    logic [1:0] mRxd = 2'b00;
    longint     errQ[$];
    int         phase = 0;
    bit         pendBehind = 1'b0;
    longint     asks[N];

    always #5 sys_clk = ~sys_clk;

    rx_perf_monitor_if #(.LFSR_LEN(LFSR_LEN)) bus ();

    rx_perf_monitor #(.LFSR_LEN(LFSR_LEN)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    function automatic longint to18(input longint v);
        longint t;
        t = v % 262144;
        if (t < 0) t += 262144;
        if (t >= 131072) t -= 262144;
        return t;
    endfunction

    function automatic logic [1:0] sliceOf(input longint x, input longint r);
        if (x >= r)  return 2'b10;
        if (x >= 0)  return 2'b11;
        if (x > -r)  return 2'b01;
        return 2'b00;
    endfunction

    function automatic longint levelOf(input logic [1:0] d, input longint r);
        case (d)
            2'b11:   return r / 2;
            2'b01:   return -(r / 2);
            2'b10:   return (3 * r) / 2;
            default: return -((3 * r) / 2);
        endcase
    endfunction

    function automatic longint satErr(input longint v);
        if (v > 131071)  return 131071;
        if (v < -131071) return -131071;
        return v;
    endfunction

    function automatic longint randX();
        logic signed [17:0] v;
        v = 18'($urandom);
        return longint'(v);
    endfunction

    task automatic modelStep(input bit rst, input bit en, input bit cp, input bit cpb, input longint x);
        longint e, sumE, sumSq, ax;
        logic [1:0] d;
        if (rst) begin
            mR = 0; mAvg = 0; mSqFull = 0; mSqDec = 0; mDc = 0; mS = 0;
            absSum = 0; pwrSum = 0; mRxd = 2'b00;
            errQ.delete();
        end else if (en) begin
            e = satErr(mS - levelOf(mRxd, mR));
            if (cpb) begin
                sumE = 0;
                sumSq = 0;
                foreach (errQ[i]) begin
                    sumE  += errQ[i];
                    sumSq += errQ[i] * errQ[i];
                end
                mSqFull = sumSq;
                mSqDec  = to18(sumSq >>> (LFSR_LEN + 17));
                if (DC_BUILT) mDc = to18(sumE >>> LFSR_LEN);
                errQ.delete();
            end
            errQ.push_back(e);
            d  = sliceOf(x, mR);
            ax = (x < 0) ? ((x == -131072) ? 131071 : -x) : x;
            if (cp) begin
                mR     = to18(absSum >>> LFSR_LEN);
                mAvg   = to18((pwrSum >>> LFSR_LEN) >>> 17);
                absSum = 0;
                pwrSum = 0;
            end
            absSum += ax;
            pwrSum += x * x;
            mRxd = d;
            mS   = x;
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit cp, input bit cpb, input longint x);
        expT ex;
        reset                     = rst;
        bus.sym_clk_en            = en;
        bus.cycle_periodic        = cp;
        bus.cycle_periodic_behind = cpb;
        bus.rx_channel_sync       = 18'(x);
        bus.sam_clk_en            = 1'($urandom);
        modelStep(rst, en, cp, cpb, x);
        ex.rxData   = mRxd;
        ex.refLevel = mR;
        ex.avgPower = mAvg;
        ex.sqDec    = mSqDec;
        ex.sqFull   = mSqFull;
        ex.dcErr    = mDc;
        expQ.push_back(ex);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic sendSymbol(input longint x);
        bit cp, cpb;
        cp         = (phase == 0);
        cpb        = pendBehind;
        pendBehind = cp;
        phase      = (phase + 1) % N;
        applyStimulus(1'b0, 1'b1, cp, cpb, x);
    endtask

    task automatic idleClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, randX());
    endtask

    task automatic checkSteady(input string tag);
        checkOutput({tag, " ref_level"},      64'(bus.ref_level),      65536);
        checkOutput({tag, " avg_power"},      64'(bus.avg_power),      32768);
        checkOutput({tag, " rx_data"},        64'(bus.rx_data),        2);
        checkOutput({tag, " acc_dc_err"},     64'(bus.acc_dc_err),     DC_STEADY);
        checkOutput({tag, " acc_sq_err_dec"}, 64'(bus.acc_sq_err_dec), 8192);
        checkOutput({tag, " acc_sq_err_full"}, 64'(bus.acc_sq_err_full), 64'sd274877906944);
    endtask

    // Monitor: one prediction per clock, compared on the falling edge.
    initial begin : monitor
        expT ex;
        forever begin
            @(negedge sys_clk);
            if (expQ.size() > 0) begin
                ex = expQ.pop_front();
                checkOutput("sb rx_data",         64'(bus.rx_data),         64'(ex.rxData));
                checkOutput("sb ref_level",       64'(bus.ref_level),       ex.refLevel);
                checkOutput("sb avg_power",       64'(bus.avg_power),       ex.avgPower);
                checkOutput("sb acc_sq_err_dec",  64'(bus.acc_sq_err_dec),  ex.sqDec);
                checkOutput("sb acc_sq_err_full", 64'(bus.acc_sq_err_full), ex.sqFull);
                checkOutput("sb acc_dc_err",      64'(bus.acc_dc_err),      ex.dcErr);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected run to complete");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin : stimulus
        longint     lvls[4];
        longint     bx[5];
        logic [1:0] bd[5];
        longint     tmp;
        int         j;

        lvls = '{98304, 32768, -32768, -98304};
        bx   = '{65535, 65536, 0, -1, -65536};
        bd   = '{2'b11, 2'b10, 2'b11, 2'b01, 2'b00};

        $display("[TB] reset");
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, randX());
        checkOutput("reset rx_data",         64'(bus.rx_data),         0);
        checkOutput("reset ref_level",       64'(bus.ref_level),       0);
        checkOutput("reset avg_power",       64'(bus.avg_power),       0);
        checkOutput("reset acc_sq_err_dec",  64'(bus.acc_sq_err_dec),  0);
        checkOutput("reset acc_sq_err_full", 64'(bus.acc_sq_err_full), 0);
        checkOutput("reset acc_dc_err",      64'(bus.acc_dc_err),      0);

        $display("[TB] constant half-scale input");
        repeat (514) sendSymbol(65536);
        checkSteady("const");

        $display("[TB] ideal 4-ASK");
        for (int i = 0; i < N; i++) asks[i] = lvls[i % 4];
        for (int i = N - 1; i > 0; i--) begin
            j       = int'($urandom_range(0, i));
            tmp     = asks[i];
            asks[i] = asks[j];
            asks[j] = tmp;
        end
        repeat (768) sendSymbol(asks[phase]);
        checkOutput("ask ref_level",       64'(bus.ref_level),       65536);
        checkOutput("ask avg_power",       64'(bus.avg_power),       40960);
        checkOutput("ask acc_sq_err_full", 64'(bus.acc_sq_err_full), 0);
        checkOutput("ask acc_dc_err",      64'(bus.acc_dc_err),      0);

        $display("[TB] slicer thresholds");
        for (int i = 0; i < 5; i++) begin
            sendSymbol(bx[i]);
            checkOutput($sformatf("slice x=%0d", bx[i]), 64'(bus.rx_data), 64'(bd[i]));
        end

        $display("[TB] symbol enable held low");
        repeat (100) idleClock();
        checkOutput("hold rx_data",   64'(bus.rx_data),   0);
        checkOutput("hold ref_level", 64'(bus.ref_level), 65536);

        $display("[TB] randomized symbols");
        repeat (600) begin
            repeat ($urandom_range(0, 2)) idleClock();
            if ($urandom_range(0, 1) != 0)
                sendSymbol(randX());
            else
                sendSymbol(asks[$urandom_range(0, N - 1)] + longint'($urandom_range(0, 8192)) - 4096);
        end

        $display("[TB] reset mid-cycle");
        repeat (37) sendSymbol(randX());
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, randX());
        checkOutput("midreset rx_data",         64'(bus.rx_data),         0);
        checkOutput("midreset ref_level",       64'(bus.ref_level),       0);
        checkOutput("midreset avg_power",       64'(bus.avg_power),       0);
        checkOutput("midreset acc_sq_err_full", 64'(bus.acc_sq_err_full), 0);
        checkOutput("midreset acc_dc_err",      64'(bus.acc_dc_err),      0);
        while (phase != 0) sendSymbol(65536);
        repeat (514) sendSymbol(65536);
        checkSteady("post-reset");

        repeat (3) idleClock();
        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge sys_clk);
        checkOutput("queue drain", 64'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
